// File: rtl/bridge_arb_pkg.sv
// Shared types and defaults for the multi-master AHB-to-APB bridge arbiter.
package bridge_arb_pkg;

  localparam int ADDR_W      = 7;
  localparam int DATA_W      = 32;
  localparam int N_MST_DEF   = 4;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // Round-robin successor of idx among n masters.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/bridge_arbiter_if.sv
// Master request/response bundle plus the AHB-side bridge signals.
interface bridge_arbiter_if #(
  parameter int N_MST = bridge_arb_pkg::N_MST_DEF
);
  import bridge_arb_pkg::*;

  logic [N_MST-1:0]             req;
  logic [N_MST-1:0]             wr;
  logic [N_MST-1:0][ADDR_W-1:0] addr;
  logic [N_MST-1:0][DATA_W-1:0] wdata;
  logic [N_MST-1:0]             ack;
  logic [N_MST-1:0]             err;
  logic [DATA_W-1:0]            rdata;

  logic              HSEL;
  logic              HWRITE;
  logic              HREADY;
  logic [ADDR_W-1:0] HADDR;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADYOUT;
  logic [DATA_W-1:0] HRDATA;

  // slave: the arbiter itself
  modport slave (
    input  req, wr, addr, wdata, HREADYOUT, HRDATA,
    output ack, err, rdata, HSEL, HWRITE, HREADY, HADDR, HWDATA
  );

  // master: the requesters and the bridge model around the arbiter
  modport master (
    output req, wr, addr, wdata, HREADYOUT, HRDATA,
    input  ack, err, rdata, HSEL, HWRITE, HREADY, HADDR, HWDATA
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    int            j;
    logic [PW-1:0] sel;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    sel = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      sel = PW'(j);
      if (!any && req[sel]) begin
        any      = 1'b1;
        gnt[sel] = 1'b1;
        idx      = sel;
      end
    end
  end

endmodule

// File: rtl/bridge_arbiter.sv
// Round-robin arbiter funnelling N_MST simple requesters onto one AHB-to-APB
// bridge; one transfer in flight, with a data-phase watchdog.
module bridge_arbiter
  import bridge_arb_pkg::*;
#(
  parameter int N_MST   = N_MST_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic              HCLK,
  input logic              RESET,
  bridge_arbiter_if.slave  bus
);

  localparam int PW = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           state, state_nxt;
  cmd_t             cmd;
  logic [PW-1:0]    ptr, gidx, win_idx;
  logic [N_MST-1:0] gnt_q, win_gnt, arb_req;
  logic             any;
  logic [TW-1:0]    timer;
  logic             done, tout;

  // A master still holds req during its ack/err cycle; keep it out of that
  // cycle's arbitration so a finished request is not granted twice.
  assign arb_req = bus.req & ~(bus.ack | bus.err);

  rr_arbiter #(.N(N_MST)) u_rr (
    .req (arb_req),
    .ptr (ptr),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (any)
  );

  always_ff @(posedge HCLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    done       = 1'b0;
    tout       = 1'b0;
    bus.HSEL   = 1'b0;
    bus.HREADY = 1'b1;
    bus.HWRITE = cmd.wr;
    bus.HADDR  = cmd.addr;
    bus.HWDATA = cmd.wdata;
    case (state)
      S_IDLE: if (any) state_nxt = S_ADDR;
      S_ADDR: begin
        bus.HSEL  = 1'b1;
        state_nxt = S_DATA;
      end
      S_DATA: begin
        bus.HREADY = bus.HREADYOUT;
        if (bus.HREADYOUT) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          tout      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge RESET) begin
    if (RESET) begin
      cmd       <= '0;
      ptr       <= '0;
      gidx      <= '0;
      gnt_q     <= '0;
      timer     <= '0;
      bus.ack   <= '0;
      bus.err   <= '0;
      bus.rdata <= '0;
    end else begin
      bus.ack <= '0;
      bus.err <= '0;
      if (state == S_IDLE && any) begin
        cmd.wr    <= bus.wr[win_idx];
        cmd.addr  <= bus.addr[win_idx];
        cmd.wdata <= bus.wdata[win_idx];
        gidx      <= win_idx;
        gnt_q     <= win_gnt;
      end
      // Consecutive wait-state count; cleared whenever the bridge is ready
      // or we are outside the data phase.
      if (state == S_DATA && !bus.HREADYOUT && !tout) timer <= timer + TW'(1);
      else                                            timer <= '0;
      if (done) begin
        bus.ack <= gnt_q;
        if (!cmd.wr) bus.rdata <= bus.HRDATA;
        ptr <= PW'(wrap_inc(int'(gidx), N_MST));
      end
      if (tout) begin
        bus.err <= gnt_q;
        ptr     <= PW'(wrap_inc(int'(gidx), N_MST));
      end
    end
  end

endmodule

// File: tb/tb_bridge_arbiter.sv
// Directed bench for bridge_arbiter: transaction table plus timeout and
// mid-transfer reset sequences.
module tb_bridge_arbiter;

  logic HCLK;
  logic RESET;

  bridge_arbiter_if #(.N_MST(4)) bus ();

  bridge_arbiter #(.N_MST(4), .TIMEOUT(16)) dut (
    .HCLK  (HCLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  wr;
    int          hro_wait;
    logic [31:0] hrdata;
    logic [3:0]  exp_ack;
    logic [6:0]  exp_haddr;
    logic        exp_hwrite;
    logic [31:0] exp_hwdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[13];
  vec_t v;
  int   nvec;
  int   nerr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    nvec++;
    if (act !== exp_v) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
    end
  endtask

  task automatic run_vec(input vec_t t, input string tag);
    int lat;
    bit seen;
    @(negedge HCLK);
    bus.req       = t.req;
    bus.wr        = t.wr;
    bus.HRDATA    = t.hrdata;
    bus.HREADYOUT = 1'b0;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 8) begin
      @(posedge HCLK); #1;
      lat++;
      if (bus.HSEL) seen = 1'b1;
    end
    chk({tag, " grant_lat"}, 32'(lat), 32'd1);
    if (!seen) return;
    chk({tag, " haddr"}, 32'(bus.HADDR), 32'(t.exp_haddr));
    chk({tag, " hwrite"}, 32'(bus.HWRITE), 32'(t.exp_hwrite));
    chk({tag, " addr_quiet"}, 32'(bus.ack | bus.err), 32'd0);
    @(posedge HCLK); #1;
    chk({tag, " data_phase"}, {bus.HSEL, bus.HREADY, 30'd0}, 32'd0);
    chk({tag, " hwdata"}, bus.HWDATA, t.exp_hwdata);
    repeat (t.hro_wait) @(posedge HCLK);
    @(negedge HCLK);
    bus.HREADYOUT = 1'b1;
    @(posedge HCLK); #1;
    chk({tag, " ack"}, 32'(bus.ack), 32'(t.exp_ack));
    chk({tag, " err"}, 32'(bus.err), 32'd0);
    chk({tag, " rdata"}, bus.rdata, t.exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  seen;
    bit  quiet;
    nvec = 0;
    nerr = 0;

    tbl[0]  = '{4'b0001, 4'b0001, 2, 32'h0,        4'b0001, 7'h25, 1'b1, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{4'b0100, 4'b0000, 0, 32'h12345678, 4'b0100, 7'h4A, 1'b0, 32'h0BAD0002, 32'h12345678};
    tbl[2]  = '{4'b1000, 4'b1000, 1, 32'hFFFFFFFF, 4'b1000, 7'h63, 1'b1, 32'h5A5A0003, 32'h12345678};
    tbl[3]  = '{4'b1111, 4'b0101, 0, 32'h0,        4'b0001, 7'h25, 1'b1, 32'hDEADBEEF, 32'h12345678};
    tbl[4]  = '{4'b1111, 4'b0101, 1, 32'hA1A1A1A1, 4'b0010, 7'h11, 1'b0, 32'hCAFE0001, 32'hA1A1A1A1};
    tbl[5]  = '{4'b1111, 4'b0101, 0, 32'h0,        4'b0100, 7'h4A, 1'b1, 32'h0BAD0002, 32'hA1A1A1A1};
    tbl[6]  = '{4'b1111, 4'b0101, 2, 32'hB3B3B3B3, 4'b1000, 7'h63, 1'b0, 32'h5A5A0003, 32'hB3B3B3B3};
    tbl[7]  = '{4'b1111, 4'b0101, 0, 32'h0,        4'b0001, 7'h25, 1'b1, 32'hDEADBEEF, 32'hB3B3B3B3};
    tbl[8]  = '{4'b1000, 4'b0000, 0, 32'h33330003, 4'b1000, 7'h63, 1'b0, 32'h5A5A0003, 32'h33330003};
    tbl[9]  = '{4'b1001, 4'b0000, 1, 32'h00000010, 4'b0001, 7'h25, 1'b0, 32'hDEADBEEF, 32'h00000010};
    tbl[10] = '{4'b1001, 4'b1001, 0, 32'h0,        4'b1000, 7'h63, 1'b1, 32'h5A5A0003, 32'h00000010};
    tbl[11] = '{4'b0110, 4'b0000, 0, 32'h00000012, 4'b0010, 7'h11, 1'b0, 32'hCAFE0001, 32'h00000012};
    tbl[12] = '{4'b0110, 4'b0100, 3, 32'h0,        4'b0100, 7'h4A, 1'b1, 32'h0BAD0002, 32'h00000012};

    RESET         = 1'b1;
    bus.req       = '0;
    bus.wr        = '0;
    bus.addr      = {7'h63, 7'h4A, 7'h11, 7'h25};
    bus.wdata     = {32'h5A5A0003, 32'h0BAD0002, 32'hCAFE0001, 32'hDEADBEEF};
    bus.HREADYOUT = 1'b0;
    bus.HRDATA    = '0;

    repeat (2) @(posedge HCLK);
    #1;
    chk("rst hsel_hready_hwrite", {29'd0, bus.HSEL, bus.HREADY, bus.HWRITE}, 32'b010);
    chk("rst haddr", 32'(bus.HADDR), 32'd0);
    chk("rst hwdata", bus.HWDATA, 32'd0);
    chk("rst ack_err", {24'd0, bus.ack, bus.err}, 32'd0);
    chk("rst rdata", bus.rdata, 32'd0);
    @(negedge HCLK);
    RESET = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Watchdog abort: master 1 stalls forever, ptr=3 so master 1 wins.
    @(negedge HCLK);
    bus.req       = 4'b0010;
    bus.wr        = 4'b0010;
    bus.HREADYOUT = 1'b0;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 8) begin
      @(posedge HCLK); #1;
      lat++;
      if (bus.HSEL) seen = 1'b1;
    end
    chk("to grant_lat", 32'(lat), 32'd1);
    chk("to haddr", 32'(bus.HADDR), 32'h11);
    @(posedge HCLK);
    quiet = 1'b1;
    for (int k = 1; k < 16; k++) begin
      @(posedge HCLK); #1;
      if ((bus.ack | bus.err) != 4'b0000) quiet = 1'b0;
    end
    chk("to quiet_before", 32'(quiet), 32'd1);
    @(posedge HCLK); #1;
    chk("to err", 32'(bus.err), 32'b0010);
    chk("to no_ack", 32'(bus.ack), 32'd0);
    @(negedge HCLK);
    bus.req = '0;
    @(posedge HCLK); #1;
    chk("to err_pulse", 32'(bus.err), 32'd0);
    v = '{4'b0011, 4'b0000, 0, 32'h77777777, 4'b0001, 7'h25, 1'b0, 32'hDEADBEEF, 32'h77777777};
    run_vec(v, "after_to");

    // Reset in the middle of a data phase (ptr=1, master 2 write).
    @(negedge HCLK);
    bus.req       = 4'b0100;
    bus.wr        = 4'b0100;
    bus.HREADYOUT = 1'b0;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 8) begin
      @(posedge HCLK); #1;
      lat++;
      if (bus.HSEL) seen = 1'b1;
    end
    chk("mid grant_lat", 32'(lat), 32'd1);
    @(posedge HCLK); #1;
    @(posedge HCLK); #2;
    RESET = 1'b1;
    #1;
    chk("mid hsel_hready_hwrite", {29'd0, bus.HSEL, bus.HREADY, bus.HWRITE}, 32'b010);
    chk("mid haddr", 32'(bus.HADDR), 32'd0);
    chk("mid hwdata", bus.HWDATA, 32'd0);
    chk("mid rdata", bus.rdata, 32'd0);
    bus.req       = '0;
    bus.HREADYOUT = 1'b1;
    quiet = 1'b1;
    repeat (2) begin
      @(posedge HCLK); #1;
      if ((bus.ack | bus.err) != 4'b0000) quiet = 1'b0;
    end
    chk("mid no_ack_err", 32'(quiet), 32'd1);
    @(negedge HCLK);
    RESET         = 1'b0;
    bus.HREADYOUT = 1'b0;
    v = '{4'b1111, 4'b0000, 0, 32'h0000ABCD, 4'b0001, 7'h25, 1'b0, 32'hDEADBEEF, 32'h0000ABCD};
    run_vec(v, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
